wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
//  Round-robin Wishbone arbiter. Shares one slave port (e.g. pwm register bank) between
//  NUM_M masters (potato core, pci_mini bridge, ...). Grant is held for a whole bus cycle (m_cyc).
//  A watchdog terminates cycles the slave never acknowledges. Sits between masters and slave in top.
// PARAMETERS
//  NUM_M    2   number of masters, 2..4
//  ADDR_W   32  address width
//  DATA_W   32  data width
//  SEL_W    4   byte-select width (DATA_W/8)
//  TMO      255 cycles of stb without ack before timeout, 1..1023
// PORTS
//  clk        in   1              single clock, all logic rising-edge
//  reset      in   1              synchronous, active-high
//  m_cyc      in   NUM_M          per-master cyc
//  m_stb      in   NUM_M          per-master stb
//  m_we       in   NUM_M          per-master write enable
//  m_adr      in   NUM_M*ADDR_W   flattened addresses, master i at [i*ADDR_W +: ADDR_W]
//  m_dat_w    in   NUM_M*DATA_W   flattened write data
//  m_sel      in   NUM_M*SEL_W    flattened byte selects
//  m_ack      out  NUM_M          ack routed to owner only
//  m_err      out  NUM_M          timeout error pulse to owner only
//  m_dat_r    out  DATA_W         slave read data, broadcast to all masters
//  m_gnt      out  NUM_M          one-hot current grant (debug/led)
//  s_cyc      out  1              to slave
//  s_stb      out  1
//  s_we       out  1
//  s_adr      out  ADDR_W
//  s_dat_w    out  DATA_W
//  s_sel      out  SEL_W
//  s_ack      in   1              from slave
//  s_dat_r    in   DATA_W
// BEHAVIOUR
//  Reset: state=IDLE, m_gnt=0, s_cyc=s_stb=s_we=0, s_adr/s_dat_w/s_sel=0, m_ack=m_err=0,
//   rr pointer=0 (master 0 highest priority first), timeout counter=0. Reset mid-cycle aborts
//   the cycle: s_cyc drops at the reset edge; no ack/err is issued.
//  FSM: IDLE -> BUSY -> (IDLE | ERR).
//   IDLE: if any m_cyc, register grant to first requester at or after rr pointer (wrapping
//     NUM_M-1 -> 0); go BUSY. Latency: m_cyc seen at edge N -> m_gnt and s_cyc high after N+1.
//   BUSY: slave outputs are a combinational mux of the owner's signals; s_cyc = m_cyc[own],
//     s_stb = m_stb[own]. m_ack[own] = s_ack; other m_ack = 0. Back-to-back stb within one
//     cyc (bursts) keep the grant. When m_cyc[own] falls: m_gnt clears, rr pointer = own+1 (mod
//     NUM_M), go IDLE. One IDLE cycle is mandatory between owners (no same-edge handoff).
//   Timeout: counter increments each BUSY cycle with s_stb=1 and s_ack=0; clears on s_ack or
//     s_stb=0. Reaching TMO: m_err[own] pulses 1 cycle, s_cyc/s_stb forced 0, go ERR.
//   ERR: slave outputs held 0; wait until m_cyc[own]=0, then advance rr pointer, go IDLE.
//  Simultaneous: s_ack on the same edge the counter would reach TMO -> ack wins, no err.
//   Owner drops cyc same cycle as s_ack -> ack still passed through (combinational).
//   Non-owner requests are held pending; never dropped; no starvation (max wait NUM_M-1 cycles
//   of other owners).
//  m_dat_r = s_dat_r unconditionally. Ack/err never reach a master without grant.
//  Width rules: counter width = $clog2(TMO+1); rr pointer width = $clog2(NUM_M).
// STRUCTURE
//  Package wb_arb_pkg: state enum {IDLE, BUSY, ERR}, localparam MAX_M=4, onehot/index helpers.
//  Sub-module rr_pick: combinational round-robin picker (req, ptr -> one-hot gnt, valid).
//  Top of block: FSM, rr pointer, timeout counter, owner mux.
// TESTING
//  Single req: m_cyc[0]=stb=1, adr=0x10, s_ack after 2 cycles -> gnt=01 at +1, m_ack[0]=1 once.
//  Contention: m_cyc=11 at same edge after reset -> master 0 first, then 1, then 0 (alternate).
//  Burst: master 1 holds cyc for 4 stb/ack pairs -> gnt=10 throughout, master 0 waits, then owns.
//  Timeout TMO=8: slave never acks -> m_err[own] pulse at 8th stall cycle, s_cyc=0, ERR until
//   m_cyc drops, next requester granted.
//  Ack/timeout race: s_ack on 8th stall cycle -> m_ack=1, m_err=0, stays BUSY.
//  Reset mid-burst: reset=1 during BUSY -> all outputs 0 next edge, master 0 wins first afterwards.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } arb_state_e;

  localparam int MAX_M = 4;

  function automatic logic [MAX_M-1:0] onehot_of(input int unsigned idx);
    return {{(MAX_M-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping to 0.
module rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int PTR_W = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NUM_M-1:0] gnt,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  // Two passes: indices at/after ptr win over the wrapped-around ones.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int j = 0; j < NUM_M; j++) begin
      if (!valid && req[j] && (j >= int'(ptr))) begin
        valid = 1'b1;
        idx   = PTR_W'(j);
        gnt   = NUM_M'(onehot_of(j));
      end else begin
        valid = valid;
      end
    end
    for (int j = 0; j < NUM_M; j++) begin
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = PTR_W'(j);
        gnt   = NUM_M'(onehot_of(j));
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_M masters share one slave port, grant held for a whole
// cyc, with a stall watchdog that terminates cycles the slave never acknowledges.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4,
  parameter int TMO    = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_M-1:0]          m_cyc,
  input  logic [NUM_M-1:0]          m_stb,
  input  logic [NUM_M-1:0]          m_we,
  input  logic [NUM_M*ADDR_W-1:0]   m_adr,
  input  logic [NUM_M*DATA_W-1:0]   m_dat_w,
  input  logic [NUM_M*SEL_W-1:0]    m_sel,
  output logic [NUM_M-1:0]          m_ack,
  output logic [NUM_M-1:0]          m_err,
  output logic [DATA_W-1:0]         m_dat_r,
  output logic [NUM_M-1:0]          m_gnt,
  output logic                      s_cyc,
  output logic                      s_stb,
  output logic                      s_we,
  output logic [ADDR_W-1:0]         s_adr,
  output logic [DATA_W-1:0]         s_dat_w,
  output logic [SEL_W-1:0]          s_sel,
  input  logic                      s_ack,
  input  logic [DATA_W-1:0]         s_dat_r
);

  localparam int PTR_W = $clog2(NUM_M);
  localparam int CNT_W = $clog2(TMO + 1);

  arb_state_e       state_r, state_s;
  logic [PTR_W-1:0] ptr_r, own_r;
  logic [CNT_W-1:0] cnt_r;
  logic [NUM_M-1:0] gnt_r, err_r;
  logic [NUM_M-1:0] pick_gnt_s;
  logic [PTR_W-1:0] pick_idx_s;
  logic             pick_valid_s;
  logic             stall_s;

  logic [ADDR_W-1:0] adr_a [NUM_M];
  logic [DATA_W-1:0] dat_a [NUM_M];
  logic [SEL_W-1:0]  sel_a [NUM_M];

  for (genvar g = 0; g < NUM_M; g++) begin : g_unpack
    assign adr_a[g] = m_adr[g*ADDR_W +: ADDR_W];
    assign dat_a[g] = m_dat_w[g*DATA_W +: DATA_W];
    assign sel_a[g] = m_sel[g*SEL_W +: SEL_W];
  end

  rr_pick #(.NUM_M(NUM_M), .PTR_W(PTR_W)) u_pick (
    .req   (m_cyc),
    .ptr   (ptr_r),
    .gnt   (pick_gnt_s),
    .idx   (pick_idx_s),
    .valid (pick_valid_s)
  );

  assign m_gnt   = gnt_r;
  assign m_err   = err_r;
  assign m_dat_r = s_dat_r;

  // Owner mux to the slave and next-state decode; slave port is quiet outside BUSY.
  always_comb begin
    state_s = state_r;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    m_ack   = '0;
    stall_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) state_s = BUSY;
        else              state_s = IDLE;
      end
      BUSY: begin
        s_cyc   = m_cyc[own_r];
        s_stb   = m_stb[own_r];
        s_we    = m_we[own_r];
        s_adr   = adr_a[own_r];
        s_dat_w = dat_a[own_r];
        s_sel   = sel_a[own_r];
        m_ack   = gnt_r & {NUM_M{s_ack}};
        stall_s = m_stb[own_r] & ~s_ack;
        // A cycle the owner abandons ends cleanly even if it was about to time out.
        if (!m_cyc[own_r])                            state_s = IDLE;
        else if (stall_s && (cnt_r == CNT_W'(TMO - 1))) state_s = ERR;
        else                                          state_s = BUSY;
      end
      ERR: begin
        if (!m_cyc[own_r]) state_s = IDLE;
        else               state_s = ERR;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, grant, round-robin pointer, watchdog counter and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      own_r   <= '0;
      cnt_r   <= '0;
      gnt_r   <= '0;
      err_r   <= '0;
    end else begin
      state_r <= state_s;
      err_r   <= '0;
      if ((state_r == BUSY) && (state_s == BUSY) && stall_s) cnt_r <= cnt_r + CNT_W'(1'b1);
      else                                                   cnt_r <= '0;
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            own_r <= pick_idx_s;
            gnt_r <= pick_gnt_s;
          end
        end
        BUSY, ERR: begin
          if (state_s == IDLE) begin
            gnt_r <= '0;
            ptr_r <= PTR_W'(rr_next(32'(own_r), 32'(NUM_M)));
          end else if ((state_r == BUSY) && (state_s == ERR)) begin
            err_r <= gnt_r;
          end
        end
        default: gnt_r <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with an owner/stall-count reference model checked every cycle.
module tb_wb_rr_arbiter;

  localparam int NUM_M  = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;
  localparam int TMO    = 8;

  logic clk = 1'b0;
  logic reset;
  logic [NUM_M-1:0]        m_cyc, m_stb, m_we, m_ack, m_err, m_gnt;
  logic [NUM_M*ADDR_W-1:0] m_adr;
  logic [NUM_M*DATA_W-1:0] m_dat_w;
  logic [NUM_M*SEL_W-1:0]  m_sel;
  logic [DATA_W-1:0]       m_dat_r, s_dat_w, s_dat_r;
  logic                    s_cyc, s_stb, s_we, s_ack;
  logic [ADDR_W-1:0]       s_adr;
  logic [SEL_W-1:0]        s_sel;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W), .TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel),
    .m_ack(m_ack), .m_err(m_err), .m_dat_r(m_dat_r), .m_gnt(m_gnt),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
    .s_ack(s_ack), .s_dat_r(s_dat_r)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    s_dat_r = s_dat_r + 32'h1111_0001;
  endtask

  task automatic set_m(input int i, input bit cyc, input bit stb, input logic [31:0] adr);
    m_cyc[i] = cyc;
    m_stb[i] = stb;
    m_we[i]  = adr[4];
    m_adr[i*ADDR_W +: ADDR_W]   = adr;
    m_dat_w[i*DATA_W +: DATA_W] = ~adr;
    m_sel[i*SEL_W +: SEL_W]     = adr[3:0] | 4'h1;
  endtask

  // Reference model: who owns the bus, whether its cycle was killed, consecutive stalls.
  int owner   = -1;
  bit errored = 1'b0;
  int nxt     = 0;
  int stalls  = 0;
  bit err_now = 1'b0;
  bit chk_en  = 1'b0;

  always @(posedge clk) begin
    chk_en  = 1'b1;
    err_now = 1'b0;
    if (reset) begin
      owner = -1; errored = 1'b0; nxt = 0; stalls = 0;
    end else if (owner < 0) begin
      for (int k = 0; k < NUM_M; k++)
        if (owner < 0 && m_cyc[(nxt + k) % NUM_M]) owner = (nxt + k) % NUM_M;
      stalls = 0;
    end else if (!m_cyc[owner]) begin
      nxt = (owner + 1) % NUM_M; owner = -1; errored = 1'b0; stalls = 0;
    end else if (!errored) begin
      if (m_stb[owner] && !s_ack) begin
        stalls++;
        if (stalls == TMO) begin errored = 1'b1; err_now = 1'b1; stalls = 0; end
      end else begin
        stalls = 0;
      end
    end
  end

  always @(negedge clk) begin
    int o;
    bit act;
    logic [NUM_M-1:0] oh;
    if (chk_en) begin
      o   = (owner < 0) ? 0 : owner;
      oh  = '0;
      if (owner >= 0) oh[o] = 1'b1;
      act = (owner >= 0) && !errored;
      check("cmp_gnt",   m_gnt,   oh);
      check("cmp_s_cyc", s_cyc,   act & m_cyc[o]);
      check("cmp_s_stb", s_stb,   act & m_stb[o]);
      check("cmp_s_we",  s_we,    act & m_we[o]);
      check("cmp_s_adr", s_adr,   act ? m_adr[o*ADDR_W +: ADDR_W] : 32'h0);
      check("cmp_s_dat", s_dat_w, act ? m_dat_w[o*DATA_W +: DATA_W] : 32'h0);
      check("cmp_s_sel", s_sel,   act ? m_sel[o*SEL_W +: SEL_W] : 4'h0);
      check("cmp_m_ack", m_ack,   (act && s_ack) ? oh : 2'b00);
      check("cmp_m_err", m_err,   err_now ? oh : 2'b00);
      check("cmp_dat_r", m_dat_r, s_dat_r);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_w = '0; m_sel = '0;
    s_ack = 1'b0; s_dat_r = 32'h0;
    step(); step();
    check("rst_gnt", m_gnt, 2'b00);
    check("rst_scyc", s_cyc, 1'b0);
    check("rst_err", m_err, 2'b00);
    reset = 1'b0;
    step();

    // Single request, ack after two cycles.
    set_m(0, 1'b1, 1'b1, 32'h10);
    step();
    check("single_gnt", m_gnt, 2'b01);
    check("single_adr", s_adr, 32'h10);
    check("single_scyc", s_cyc, 1'b1);
    check("single_noack", m_ack, 2'b00);
    step();
    s_ack = 1'b1; #1;
    check("single_ack", m_ack, 2'b01);
    step();
    s_ack = 1'b0; set_m(0, 1'b0, 1'b0, 32'h10); #1;
    check("single_ack_once", m_ack, 2'b00);
    step();
    check("single_release", m_gnt, 2'b00);

    // Contention straight after reset: 0, 1, 0 with an idle gap between owners.
    reset = 1'b1; step(); reset = 1'b0;
    set_m(0, 1'b1, 1'b1, 32'h100);
    set_m(1, 1'b1, 1'b1, 32'h200);
    for (int g = 0; g < 3; g++) begin
      step();
      check("alt_gnt", m_gnt, (g == 1) ? 2'b10 : 2'b01);
      check("alt_adr", s_adr, (g == 1) ? 32'h200 : 32'h100);
      s_ack = 1'b1;
      step();
      s_ack = 1'b0;
      set_m((g == 1) ? 1 : 0, 1'b0, 1'b0, (g == 1) ? 32'h200 : 32'h100);
      step();
      check("alt_gap", m_gnt, 2'b00);
      set_m((g == 1) ? 1 : 0, 1'b1, 1'b1, (g == 1) ? 32'h200 : 32'h100);
    end

    // Burst: master 1 keeps cyc for four beats while master 0 waits.
    step();
    check("burst_gnt", m_gnt, 2'b10);
    for (int b = 0; b < 4; b++) begin
      set_m(1, 1'b1, 1'b1, 32'h300 + 32'(4 * b));
      s_ack = 1'b1; #1;
      check("burst_ack", m_ack, 2'b10);
      check("burst_adr", s_adr, 32'h300 + 32'(4 * b));
      step();
      s_ack = 1'b0;
      set_m(1, 1'b1, 1'b0, 32'h300);
      step();
      check("burst_hold", m_gnt, 2'b10);
    end
    set_m(1, 1'b0, 1'b0, 32'h0);
    step();
    check("burst_gap", m_gnt, 2'b00);
    step();
    check("burst_next", m_gnt, 2'b01);
    s_ack = 1'b1; step(); s_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0);
    step();

    // Timeout: slave never acks master 0; master 1 gets the bus afterwards.
    set_m(0, 1'b1, 1'b1, 32'h40);
    step();
    check("tmo_gnt", m_gnt, 2'b01);
    set_m(1, 1'b1, 1'b1, 32'h50);
    for (int k = 1; k < TMO; k++) begin
      step();
      check("tmo_wait_err", m_err, 2'b00);
      check("tmo_wait_scyc", s_cyc, 1'b1);
    end
    step();
    check("tmo_err", m_err, 2'b01);
    check("tmo_kill", s_cyc, 1'b0);
    check("tmo_gnt_held", m_gnt, 2'b01);
    step();
    check("tmo_pulse", m_err, 2'b00);
    check("tmo_err_hold", s_cyc, 1'b0);
    set_m(0, 1'b0, 1'b0, 32'h0);
    step();
    check("tmo_gap", m_gnt, 2'b00);
    step();
    check("tmo_next", m_gnt, 2'b10);
    s_ack = 1'b1; step(); s_ack = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h0);
    step();

    // Ack arrives on the stall cycle that would otherwise time out.
    set_m(0, 1'b1, 1'b1, 32'h60);
    step();
    for (int k = 1; k < TMO; k++) step();
    s_ack = 1'b1; #1;
    check("race_ack", m_ack, 2'b01);
    step();
    s_ack = 1'b0;
    check("race_noerr", m_err, 2'b00);
    check("race_busy", s_cyc, 1'b1);
    check("race_gnt", m_gnt, 2'b01);
    set_m(0, 1'b0, 1'b0, 32'h0);
    step();

    // Reset while master 1 owns the bus; master 0 wins afterwards.
    set_m(0, 1'b1, 1'b1, 32'h70);
    set_m(1, 1'b1, 1'b1, 32'h80);
    step();
    check("rstmid_gnt", m_gnt, 2'b10);
    reset = 1'b1;
    step();
    check("rstmid_gnt0", m_gnt, 2'b00);
    check("rstmid_scyc", s_cyc, 1'b0);
    check("rstmid_adr", s_adr, 32'h0);
    check("rstmid_ack", m_ack, 2'b00);
    check("rstmid_err", m_err, 2'b00);
    reset = 1'b0;
    step();
    check("rstmid_first", m_gnt, 2'b01);
    s_ack = 1'b1; step(); s_ack = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0);
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
